// File: rtl/ei_axi4_wr_arbiter.sv
// ei_axi4_wr_arbiter
// Two-master to one-slave AXI4 write-path arbiter. One write transaction is
// in flight at a time. Ties go round-robin, and m0 wins the first tie after reset.
// Optional watchdog: define EI_AXI4_WR_ARB_TIMEOUT_EN to build the sticky
// timeout_err counter. When it is undefined, timeout_err is tied to 0.
//
// state | meaning
// IDLE  | no transaction; arbitrate between pending awvalid requests
// ADDR  | granted master's AW routed to slave, waiting for AW handshake
// DATA  | granted master's W routed to slave, until the wlast handshake
// RESP  | slave B routed to granted master, waiting for B handshake
module ei_axi4_wr_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int BUS_BYTE_LANES = DATA_WIDTH / 8
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic [31:0]               m0_awaddr,
    input  logic [7:0]                m0_awlen,
    input  logic [2:0]                m0_awsize,
    input  logic [1:0]                m0_awburst,
    input  logic                      m0_awvalid,
    output logic                      m0_awready,
    input  logic [DATA_WIDTH-1:0]     m0_wdata,
    input  logic [BUS_BYTE_LANES-1:0] m0_wstrb,
    input  logic                      m0_wlast,
    input  logic                      m0_wvalid,
    output logic                      m0_wready,
    output logic [1:0]                m0_bresp,
    output logic                      m0_bvalid,
    input  logic                      m0_bready,

    input  logic [31:0]               m1_awaddr,
    input  logic [7:0]                m1_awlen,
    input  logic [2:0]                m1_awsize,
    input  logic [1:0]                m1_awburst,
    input  logic                      m1_awvalid,
    output logic                      m1_awready,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic [BUS_BYTE_LANES-1:0] m1_wstrb,
    input  logic                      m1_wlast,
    input  logic                      m1_wvalid,
    output logic                      m1_wready,
    output logic [1:0]                m1_bresp,
    output logic                      m1_bvalid,
    input  logic                      m1_bready,

    output logic [31:0]               s_awaddr,
    output logic [7:0]                s_awlen,
    output logic [2:0]                s_awsize,
    output logic [1:0]                s_awburst,
    output logic                      s_awvalid,
    input  logic                      s_awready,
    output logic [DATA_WIDTH-1:0]     s_wdata,
    output logic [BUS_BYTE_LANES-1:0] s_wstrb,
    output logic                      s_wlast,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    input  logic [1:0]                s_bresp,
    input  logic                      s_bvalid,
    output logic                      s_bready,

    output logic                      grant,
    output logic                      busy,
    output logic                      timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    logic   last_grant;   // master granted by the last completed transaction
    logic   any_req;

    // A counter shorter than two cycles makes no sense for the watchdog.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("ei_axi4_wr_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    assign any_req = m0_awvalid | m1_awvalid;
    assign busy    = (state != IDLE);

    // Transaction sequencing, round-robin grant and last-grant pointer.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= ADDR;
                        if (m0_awvalid && m1_awvalid)
                            grant <= ~last_grant;
                        else
                            grant <= m1_awvalid;
                    end
                end
                ADDR: if (s_awvalid && s_awready) state <= DATA;
                DATA: if (s_wvalid && s_wready && s_wlast) state <= RESP;
                RESP: begin
                    if (s_bvalid && s_bready) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route the active channel of the granted master. Everything else stays 0.
    always_comb begin
        s_awaddr   = '0;
        s_awlen    = '0;
        s_awsize   = '0;
        s_awburst  = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wlast    = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m1_bvalid  = 1'b0;
        m0_bresp   = '0;
        m1_bresp   = '0;
        case (state)
            ADDR: begin
                s_awaddr   = grant ? m1_awaddr  : m0_awaddr;
                s_awlen    = grant ? m1_awlen   : m0_awlen;
                s_awsize   = grant ? m1_awsize  : m0_awsize;
                s_awburst  = grant ? m1_awburst : m0_awburst;
                s_awvalid  = grant ? m1_awvalid : m0_awvalid;
                m0_awready = s_awready & ~grant;
                m1_awready = s_awready & grant;
            end
            DATA: begin
                s_wdata   = grant ? m1_wdata  : m0_wdata;
                s_wstrb   = grant ? m1_wstrb  : m0_wstrb;
                s_wlast   = grant ? m1_wlast  : m0_wlast;
                s_wvalid  = grant ? m1_wvalid : m0_wvalid;
                m0_wready = s_wready & ~grant;
                m1_wready = s_wready & grant;
            end
            RESP: begin
                s_bready  = grant ? m1_bready : m0_bready;
                m0_bvalid = s_bvalid & ~grant;
                m1_bvalid = s_bvalid & grant;
                m0_bresp  = grant ? 2'b00 : s_bresp;
                m1_bresp  = grant ? s_bresp : 2'b00;
            end
            default: ;
        endcase
    end

`ifdef EI_AXI4_WR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;

    // Watchdog: count busy cycles from ADDR entry, saturate, and latch the error.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == IDLE) begin
            if (any_req) wd_cnt <= '0;
        end else begin
            if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WD_LAST) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
